display_resultado: RTL and testbench
====================================

DISPLAY_RESULTADO -- requirements
Module: display_resultado

Interface
REQ-001 Parameter SCAN_DIV SHALL default to 50000 and give the clock cycles each digit stays lit during multiplexing (minimum 2).
REQ-002 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port result  input  14  SHALL be the unsigned magnitude from the calculator stage.
REQ-005 Port signal  input  1  SHALL be the sign from the calculator stage (1 = negative).
REQ-006 Port start  input  1  SHALL request capture and conversion of result/signal when high for one cycle.
REQ-007 Port busy  output  1  SHALL be high while a conversion is in progress.
REQ-008 Port done  output  1  SHALL pulse high for exactly one cycle when new digits are loaded.
REQ-009 Port seg  output  7  SHALL give segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port an  output  6  SHALL give active-low one-hot digit enables: an[0..4] = units..ten-thousands, an[5] = sign.

Function
REQ-011 The FSM SHALL have states IDLE, CONVERT, LOAD.
REQ-012 In IDLE with start=1, the block SHALL latch result and signal, clear a 20-bit BCD work register, enter CONVERT, and assert busy from the next cycle.
REQ-013 CONVERT SHALL run exactly 14 iterations of shift-and-add-3 (double dabble), one per cycle, MSB of the latched value first.
REQ-014 After the 14th iteration the FSM SHALL enter LOAD, copy the 5 BCD digits and latched sign to the display registers, pulse done, drop busy, and return to IDLE.
REQ-015 Latency SHALL be 16 cycles from the edge sampling start=1 to the edge at which done is high.
REQ-016 start SHALL be ignored while busy=1; inputs SHALL NOT be resampled mid-conversion.
REQ-017 Full 14-bit range 0..16383 SHALL convert exactly; no saturation is needed.
REQ-018 Leading zero digits SHALL be blanked (seg = 7'b1111111); the units digit SHALL always show, so 0 displays as "0".
REQ-019 The sign digit SHALL show "-" (7'b0111111) when the displayed sign is 1, blank otherwise; signal=1 with result=0 SHALL still show "-0".
REQ-020 A scan counter SHALL advance the active digit every SCAN_DIV cycles in order an[0],an[1],...,an[5],an[0], wrapping, independent of the FSM.
REQ-021 Exactly one an bit SHALL be low at any time after reset.
REQ-022 Digit encodings SHALL be standard 7-segment: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-023 reset SHALL force FSM to IDLE, busy=0, done=0, display digits to 0, display sign to 0, scan counter to 0 and an=6'b111110.
REQ-024 reset asserted mid-conversion SHALL abort it with no done pulse and the display showing "0".
REQ-025 reset SHALL take priority over start in the same cycle.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, NUM_DIGITS=5, BLANK and MINUS segment constants, and the digit segment table.
REQ-027 One sub-module, seg7_decoder (4-bit BCD plus blank flag -> 7 segments, combinational), SHALL be instantiated once on the multiplexed digit.
REQ-028 Display registers SHALL only change in LOAD or reset, so seg never shows partial conversions.

Verification (SCAN_DIV=4)
REQ-029 result=16129, signal=0, start pulse -> done exactly 16 cycles later, digits 1,6,1,2,9, sign blank.
REQ-030 result=0, signal=0 -> an[0] shows 1000000, an[1..5] show 1111111.
REQ-031 result=5, signal=1 -> an[0]=0010010, an[5]=0111111, an[1..4] blank.
REQ-032 start pulse every cycle for 20 cycles with changing result -> one done per 16-cycle window, value equals result at the first accepted start.
REQ-033 reset at cycle 7 of a conversion of 9999 -> no done, busy=0 next cycle, display "0".
REQ-034 Free-run 48 cycles after reset -> an walks 111110,111101,...,011111, 4 cycles each, then wraps to 111110.

Source files
------------

// File: rtl/display_resultado_pkg.sv
// rtl/display_resultado_pkg.sv - shared types and constants for the result display
package display_resultado_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LOAD    = 2'd2
   } state_t;

   localparam int NUM_DIGITS = 5;
   localparam int DATA_W     = 14;
   localparam int BCD_W      = 4 * NUM_DIGITS;

   // Segment patterns are {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] MINUS = 7'b0111111;

   // Digit table, element index = decimal digit
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   // Add-3 correction applied to every BCD digit >= 5 before each shift
   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return adj;
   endfunction

endpackage

// File: rtl/display_resultado_seg7_decoder.sv
// rtl/display_resultado_seg7_decoder.sv - BCD digit to active-low 7-segment pattern
module seg7_decoder
   import display_resultado_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   // Blanked or non-decimal codes light nothing
   always_comb begin
      seg = BLANK;
      if (!blank && (bcd <= 4'd9)) begin
         seg = SEG_TABLE[bcd];
      end
   end

endmodule

// File: rtl/display_resultado.sv
// rtl/display_resultado.sv - signed result to multiplexed 6-digit 7-segment display
module display_resultado
   import display_resultado_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] result,
   input  logic        signal,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [6:0]  seg,
   output logic [5:0]  an
);

   localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [3:0] LAST_ITER = 4'(DATA_W - 1);
   localparam logic [2:0] SIGN_POS = 3'(NUM_DIGITS);

   state_t            state;
   state_t            state_next;
   logic              capture;
   logic              step;
   logic              load;

   logic [DATA_W-1:0] shreg;
   logic [BCD_W-1:0]  bcd_work;
   logic [BCD_W-1:0]  bcd_adj;
   logic [3:0]        iter_cnt;
   logic              sign_lat;

   logic [BCD_W-1:0]  disp_bcd;
   logic              disp_sign;

   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        digit_idx;

   logic [NUM_DIGITS-1:0] lead_zero;
   logic              upper_zero;
   logic [3:0]        dec_bcd;
   logic              dec_blank;
   logic [6:0]        dig_seg;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath strobes; start only counts while idle
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      step       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               capture    = 1'b1;
               state_next = CONVERT;
            end
         end
         CONVERT: begin
            step = 1'b1;
            if (iter_cnt == LAST_ITER) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            load       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy    = (state != IDLE);
   assign bcd_adj = dabble_adjust(bcd_work);

   // Double-dabble engine: latch operands, then one shift-and-add-3 per cycle, MSB first
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg    <= '0;
         bcd_work <= '0;
         iter_cnt <= '0;
         sign_lat <= 1'b0;
      end else if (capture) begin
         shreg    <= result;
         sign_lat <= signal;
         bcd_work <= '0;
         iter_cnt <= '0;
      end else if (step) begin
         bcd_work <= {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
         shreg    <= {shreg[DATA_W-2:0], 1'b0};
         iter_cnt <= iter_cnt + 4'd1;
      end
   end

   // Display registers only change on a completed conversion, so no partial value is shown
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_bcd  <= '0;
         disp_sign <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= load;
         if (load) begin
            disp_bcd  <= bcd_work;
            disp_sign <= sign_lat;
         end
      end
   end

   // Free-running digit scan: each position stays lit for SCAN_DIV cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt  <= '0;
         digit_idx <= 3'd0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt  <= '0;
         digit_idx <= (digit_idx == SIGN_POS) ? 3'd0 : digit_idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Active-low one-hot enable for the current position
   always_comb begin
      an = ~(6'b000001 << digit_idx);
   end

   // A digit is a leading zero when it and every higher digit are zero; units never blanks
   always_comb begin
      lead_zero  = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero   = upper_zero && (disp_bcd[4*i +: 4] == 4'd0);
         lead_zero[i] = upper_zero;
      end
   end

   // Select the digit feeding the shared decoder
   always_comb begin
      dec_bcd   = 4'd0;
      dec_blank = 1'b1;
      case (digit_idx)
         3'd0: begin dec_bcd = disp_bcd[3:0];   dec_blank = lead_zero[0]; end
         3'd1: begin dec_bcd = disp_bcd[7:4];   dec_blank = lead_zero[1]; end
         3'd2: begin dec_bcd = disp_bcd[11:8];  dec_blank = lead_zero[2]; end
         3'd3: begin dec_bcd = disp_bcd[15:12]; dec_blank = lead_zero[3]; end
         3'd4: begin dec_bcd = disp_bcd[19:16]; dec_blank = lead_zero[4]; end
         default: begin dec_bcd = 4'd0; dec_blank = 1'b1; end
      endcase
   end

   seg7_decoder u_dec (
      .bcd   (dec_bcd),
      .blank (dec_blank),
      .seg   (dig_seg)
   );

   // Sign position bypasses the decoder
   always_comb begin
      seg = dig_seg;
      if (digit_idx == SIGN_POS) begin
         seg = disp_sign ? MINUS : BLANK;
      end
   end

endmodule

// File: tb/tb_display_resultado.sv
// tb/tb_display_resultado.sv - self-checking bench for display_resultado
module tb_display_resultado;

   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] result;
   logic        signal;
   logic        start;
   logic        busy;
   logic        done;
   logic [6:0]  seg;
   logic [5:0]  an;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] cap_seg [6];
   int         cap_bad;

   display_resultado #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk    (clk),
      .reset  (reset),
      .result (result),
      .signal (signal),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .seg    (seg),
      .an     (an)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] digit_pattern(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   // What position pos should show for a displayed signed value
   function automatic logic [6:0] exp_seg(input int value, input bit sgn, input int pos);
      int pw;
      if (pos == 5) return sgn ? 7'b0111111 : 7'b1111111;
      pw = 1;
      for (int i = 0; i < pos; i++) pw = pw * 10;
      if (pos > 0 && value < pw) return 7'b1111111;
      return digit_pattern((value / pw) % 10);
   endfunction

   function automatic int active_pos(input logic [5:0] a);
      int p;
      int zeros;
      p = -1;
      zeros = 0;
      for (int i = 0; i < 6; i++) begin
         if (a[i] === 1'b0) begin
            zeros++;
            p = i;
         end
      end
      return (zeros == 1) ? p : -1;
   endfunction

   task automatic pulse_start(input int value, input bit sgn);
      @(negedge clk);
      start  = 1'b1;
      result = 14'(value);
      signal = sgn;
      @(posedge clk);
      #1;
      start  = 1'b0;
      result = 14'($urandom_range(0, 16383));
      signal = 1'($urandom_range(0, 1));
   endtask

   task automatic scan_capture();
      int p;
      for (int i = 0; i < 6; i++) cap_seg[i] = 7'bxxxxxxx;
      cap_bad = 0;
      for (int c = 0; c < 6 * SCAN_DIV + 2; c++) begin
         @(negedge clk);
         p = active_pos(an);
         if (p < 0) cap_bad++;
         else cap_seg[p] = seg;
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      start  = 1'b0;
      result = '0;
      signal = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++;
      if (an !== 6'b111110) begin n_fail++; $display("FAIL reset_an: got %b expected 111110", an); end
      n_checks++;
      if (seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg: got %b expected 1000000", seg); end
      reset = 1'b0;
   endtask

   task automatic test_scan_walk();
      logic [5:0] exp_an;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c <= 48; c++) begin
         if (c > 0) @(negedge clk);
         exp_an = ~(6'b000001 << ((c / SCAN_DIV) % 6));
         n_checks++;
         if (an !== exp_an) begin
            n_fail++;
            $display("FAIL scan_walk cycle %0d: got %b expected %b", c, an, exp_an);
         end
      end
   endtask

   task automatic test_conversion();
      int  fixed_v [6] = '{16129, 0, 5, 0, 16383, 10000};
      bit  fixed_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int  v;
      bit  s;
      int  lat;
      int  done_cnt;
      int  busy_bad;
      for (int t = 0; t < 12; t++) begin
         if (t < 6) begin
            v = fixed_v[t];
            s = fixed_s[t];
         end else begin
            v = $urandom_range(0, 16383);
            s = 1'($urandom_range(0, 1));
         end
         pulse_start(v, s);
         lat = 0;
         done_cnt = 0;
         busy_bad = 0;
         for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
               done_cnt++;
               if (lat == 0) lat = n;
            end
            if (busy !== (n < 16)) busy_bad++;
         end
         n_checks++;
         if (lat != 16) begin n_fail++; $display("FAIL latency value %0d: got %0d expected 16", v, lat); end
         n_checks++;
         if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulses value %0d: got %0d expected 1", v, done_cnt); end
         n_checks++;
         if (busy_bad != 0) begin n_fail++; $display("FAIL busy_window value %0d: got %0d bad cycles expected 0", v, busy_bad); end
         scan_capture();
         n_checks++;
         if (cap_bad != 0) begin n_fail++; $display("FAIL an_onehot value %0d: got %0d bad cycles expected 0", v, cap_bad); end
         for (int p = 0; p < 6; p++) begin
            n_checks++;
            if (cap_seg[p] !== exp_seg(v, s, p)) begin
               n_fail++;
               $display("FAIL display value %0d sign %0d pos %0d: got %b expected %b", v, s, p, cap_seg[p], exp_seg(v, s, p));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc_t [$];
      int acc_v [$];
      bit acc_s [$];
      int free_at;
      int last_acc;
      int shown_v;
      bit shown_s;
      int done_cnt;
      int exp_cnt;
      int done_bad;
      int busy_bad;
      int seg_bad;
      bit exp_done;
      bit exp_busy;
      int p;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      free_at = 0;
      last_acc = -100;
      shown_v = 0;
      shown_s = 1'b0;
      done_cnt = 0;
      exp_cnt = 0;
      done_bad = 0;
      busy_bad = 0;
      seg_bad = 0;
      for (int k = 0; k < 60; k++) begin
         start  = (k < 20);
         result = 14'($urandom_range(0, 16383));
         signal = 1'($urandom_range(0, 1));
         if (start && k >= free_at) begin
            acc_t.push_back(k);
            acc_v.push_back(int'(result));
            acc_s.push_back(signal);
            free_at = k + 16;
            last_acc = k;
         end
         @(negedge clk);
         exp_done = (acc_t.size() > 0) && (acc_t[0] + 15 == k);
         exp_busy = (k >= last_acc) && (k <= last_acc + 14);
         if (done === 1'b1) done_cnt++;
         if (done !== exp_done) done_bad++;
         if (busy !== exp_busy) busy_bad++;
         if (exp_done) begin
            exp_cnt++;
            shown_v = acc_v.pop_front();
            shown_s = acc_s.pop_front();
            void'(acc_t.pop_front());
         end
         p = active_pos(an);
         if (p < 0 || seg !== exp_seg(shown_v, shown_s, p)) seg_bad++;
      end
      start = 1'b0;
      n_checks++;
      if (done_cnt != exp_cnt) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected %0d", done_cnt, exp_cnt); end
      n_checks++;
      if (done_bad != 0) begin n_fail++; $display("FAIL b2b_done_timing: got %0d bad cycles expected 0", done_bad); end
      n_checks++;
      if (busy_bad != 0) begin n_fail++; $display("FAIL b2b_busy: got %0d bad cycles expected 0", busy_bad); end
      n_checks++;
      if (seg_bad != 0) begin n_fail++; $display("FAIL b2b_display: got %0d bad cycles expected 0", seg_bad); end
   endtask

   task automatic test_reset_abort();
      int done_cnt;
      pulse_start(777, 1'b1);
      repeat (24) @(negedge clk);
      scan_capture();
      n_checks++;
      if (cap_seg[0] !== exp_seg(777, 1'b1, 0)) begin
         n_fail++;
         $display("FAIL abort_preload: got %b expected %b", cap_seg[0], exp_seg(777, 1'b1, 0));
      end
      pulse_start(9999, 1'b0);
      repeat (7) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_after: got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done_after: got %b expected 0", done); end
      reset = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         if (done !== 1'b0) done_cnt++;
      end
      n_checks++;
      if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
      scan_capture();
      for (int p = 0; p < 6; p++) begin
         n_checks++;
         if (cap_seg[p] !== exp_seg(0, 1'b0, p)) begin
            n_fail++;
            $display("FAIL abort_display pos %0d: got %b expected %b", p, cap_seg[p], exp_seg(0, 1'b0, p));
         end
      end
   endtask

   task automatic test_reset_priority();
      int done_cnt;
      int busy_cnt;
      @(negedge clk);
      reset  = 1'b1;
      start  = 1'b1;
      result = 14'd1234;
      signal = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %b expected 0", busy); end
      done_cnt = 0;
      busy_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done !== 1'b0) done_cnt++;
         if (busy !== 1'b0) busy_cnt++;
      end
      n_checks++;
      if (done_cnt != 0 || busy_cnt != 0) begin
         n_fail++;
         $display("FAIL prio_idle: got %0d done and %0d busy cycles expected 0 and 0", done_cnt, busy_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_scan_walk();
      test_conversion();
      test_back_to_back();
      test_reset_abort();
      test_reset_priority();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
